utopia_rx_cell_assembler: RTL and testbench
===========================================

Name: utopia_rx_cell_assembler

Overview:
- ATM-layer receive port for a Utopia level-1 style PHY interface.
- Pulls bytes from the PHY using the clav/en/soc handshake and assembles 53-byte UNI cells.
- Checks the header HEC and drops failing cells.
- Presents each good cell as a flat vector with a valid/ready handshake to the downstream cell forwarder/switch core.

Parameters:
- CELL_BYTES, 53, bytes per cell; cell_out width is CELL_BYTES*8.
- HEC_IDX, 4, byte index of the HEC; header bytes 0..HEC_IDX-1 are covered by the CRC.
- HEC_COSET, 8'h55, value XORed onto the CRC-8 before comparison.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_in  input  1  receive clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  8  PHY receive byte.
- soc  input  1  start-of-cell marker; qualifies byte 0.
- clav  input  1  PHY has cell data available.
- en  output  1  active-low read enable to the PHY; registered.
- cell_out  output  CELL_BYTES*8  assembled cell; byte 0 in [CELL_BYTES*8-1 -: 8].
- cell_valid  output  1  cell_out holds a good cell.
- cell_ready  input  1  downstream accepts the cell.
- hec_err  output  1  one-cycle pulse when a HEC mismatch is detected.
- cell_cnt  output  CNT_W  good cells delivered; saturating.
- hec_err_cnt  output  CNT_W  cells dropped for HEC; saturating.
- sync_err_cnt  output  CNT_W  soc protocol violations; saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - en=1; cell_valid=0; hec_err=0; all counters=0; cell_out=0; byte index=0; state=WAIT_SOC.
- Transfer rule: a byte is transferred on any rising edge at which en==0. The PHY contract is that a valid byte is present whenever en is low.
- en generation: en <= !(clav && next_state!=HOLD), evaluated every edge.
  - Dropping clav pauses reception; en goes high one edge later.
  - The partial cell is retained, and the byte index is preserved across the gap.
- States:
  - WAIT_SOC: a transferred byte with soc=0 is discarded and sync_err_cnt is incremented. A byte with soc=1 is stored as byte 0, idx=1, and the state moves to RECV.
  - RECV: each transferred byte is stored at idx, then idx increments.
    - A transferred byte with soc=1 at idx!=0 increments sync_err_cnt and restarts the cell: the byte is stored as byte 0 and idx=1.
    - On transfer of byte HEC_IDX: compute CRC-8 (poly x^8+x^2+x+1, init 0, MSB first) over bytes 0..HEC_IDX-1, XOR HEC_COSET, and compare with the byte.
      - On mismatch: hec_err pulses on that edge, hec_err_cnt increments, and the state moves to DISCARD.
    - On transfer of byte CELL_BYTES-1: the state moves to HOLD, and cell_valid is registered high on the same edge.
  - DISCARD: consume bytes until byte CELL_BYTES-1, then return to WAIT_SOC. A soc=1 byte here restarts as in RECV and counts a sync error.
  - HOLD: cell_valid=1 and en=1. cell_out is stable while cell_valid && !cell_ready.
    - On the edge with cell_ready=1: cell_valid=0, cell_cnt increments, and the state moves to WAIT_SOC.
- Latency: cell_valid rises on the edge that transfers the last byte. The minimum gap between back-to-back cells is 2 cycles: the ready edge, then en low.
- The CRC may be computed incrementally per byte or combinationally over stored header bytes. Either way the result must be available by the HEC byte's edge.
- Counters saturate at all-ones; there is no wrap-around.
- Reset mid-cell: the partial cell is discarded with no counter update, and reception resumes in WAIT_SOC.

Test Plan:
- Good cell: clav=1 throughout; header 00 00 00 00, HEC 55, payload 0x01..0x30 with soc on byte 0.
  - Required: cell_valid high on the 53rd transfer edge.
  - Required: cell_out[423:384]=00_00_00_00_55, last byte 0x30, cell_cnt=1.
- HEC error: header 00 00 00 01 with HEC 0x55 (correct is 0x52).
  - Required: hec_err pulses once at byte 4.
  - Required: no cell_valid, hec_err_cnt=1.
  - Required: the next good cell, header 00 00 00 01 with HEC 52, is delivered.
- Sync: 3 garbage bytes with soc=0 precede a good cell; separately, a second soc is injected at byte 20.
  - Required: sync_err_cnt=3 and the cell is delivered.
  - Required: the injected soc restarts the cell, which is delivered intact, and sync_err_cnt increments by 1.
- Flow control: clav low for 5 cycles at byte 10; cell_ready low for 8 cycles after cell_valid.
  - Required: en high within 1 edge of clav falling, and no byte lost or duplicated.
  - Required: cell_out stable and en=1 throughout the hold.
- Reset mid-cell: assert reset at byte 30, then send a full good cell.
  - Required: outputs return to reset values immediately.
  - Required: exactly one cell delivered, cell_cnt=1.
- Saturation: use CNT_W=2 and send 5 good cells.
  - Required: cell_cnt=3.

Source files
------------

// File: rtl/utopia_rx_cell_assembler.sv
// Utopia level-1 receive port: pulls bytes from the PHY with clav/en/soc, assembles 53-byte cells,
// drops cells whose header HEC fails and offers good cells downstream over valid/ready.
module utopia_rx_cell_assembler #(
  parameter int unsigned CELL_BYTES = 53,
  parameter int unsigned HEC_IDX    = 4,
  parameter logic [7:0]  HEC_COSET  = 8'h55,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [7:0]              data,
  input  logic                    soc,
  input  logic                    clav,
  output logic                    en,
  output logic [CELL_BYTES*8-1:0] cell_out,
  output logic                    cell_valid,
  input  logic                    cell_ready,
  output logic                    hec_err,
  output logic [CNT_W-1:0]        cell_cnt,
  output logic [CNT_W-1:0]        hec_err_cnt,
  output logic [CNT_W-1:0]        sync_err_cnt
);

  localparam int unsigned      IDX_W    = $clog2(CELL_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);
  localparam logic [IDX_W-1:0] HEC_POS  = IDX_W'(HEC_IDX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // state    | meaning
  // WAIT_SOC | hunting for a soc byte; stray bytes are sync errors
  // RECV     | storing a cell whose HEC is good or not yet checked
  // DISCARD  | draining the rest of a cell that failed HEC
  // HOLD     | cell complete, PHY reads stopped until cell_ready
  typedef enum logic [1:0] {WAIT_SOC, RECV, DISCARD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       buf_q [CELL_BYTES];
  logic [7:0]       buf_d [CELL_BYTES];
  logic             en_q, en_d;
  logic             valid_q, valid_d;
  logic             hec_err_q, hec_err_d;
  logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
  logic [CNT_W-1:0] hec_cnt_q, hec_cnt_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic             xfer;
  logic             cell_inc, hec_inc, sync_inc;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // The PHY guarantees a valid byte whenever our registered enable is low.
  assign xfer = !en_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    buf_d     = buf_q;
    valid_d   = valid_q;
    hec_err_d = 1'b0;
    cell_inc  = 1'b0;
    hec_inc   = 1'b0;
    sync_inc  = 1'b0;

    case (state_q)
      WAIT_SOC: begin
        if (xfer) begin
          if (soc) begin
            buf_d[0] = data;
            idx_d    = IDX_W'(1);
            crc_d    = crc8_next(8'h00, data);
            state_d  = RECV;
          end else begin
            sync_inc = 1'b1;
          end
        end
      end
      RECV, DISCARD: begin
        if (xfer) begin
          if (soc) begin
            sync_inc = 1'b1;
            buf_d[0] = data;
            idx_d    = IDX_W'(1);
            crc_d    = crc8_next(8'h00, data);
            state_d  = RECV;
          end else if (state_q == DISCARD) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = WAIT_SOC;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            buf_d[idx_q] = data;
            idx_d        = idx_q + 1'b1;
            if (idx_q < HEC_POS) begin
              crc_d = crc8_next(crc_q, data);
            end
            if (idx_q == HEC_POS && data != (crc_q ^ HEC_COSET)) begin
              hec_err_d = 1'b1;
              hec_inc   = 1'b1;
              state_d   = DISCARD;
            end
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (cell_ready) begin
          valid_d  = 1'b0;
          cell_inc = 1'b1;
          state_d  = WAIT_SOC;
        end
      end
      default: state_d = WAIT_SOC;
    endcase

    cell_cnt_d = (cell_inc && cell_cnt_q != CNT_MAX) ? cell_cnt_q + 1'b1 : cell_cnt_q;
    hec_cnt_d  = (hec_inc && hec_cnt_q != CNT_MAX) ? hec_cnt_q + 1'b1 : hec_cnt_q;
    sync_cnt_d = (sync_inc && sync_cnt_q != CNT_MAX) ? sync_cnt_q + 1'b1 : sync_cnt_q;
    en_d       = !(clav && state_d != HOLD);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_SOC;
      idx_q      <= '0;
      crc_q      <= '0;
      en_q       <= 1'b1;
      valid_q    <= 1'b0;
      hec_err_q  <= 1'b0;
      cell_cnt_q <= '0;
      hec_cnt_q  <= '0;
      sync_cnt_q <= '0;
      for (int i = 0; i < CELL_BYTES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      hec_err_q  <= hec_err_d;
      cell_cnt_q <= cell_cnt_d;
      hec_cnt_q  <= hec_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      buf_q      <= buf_d;
    end
  end

  for (genvar g = 0; g < CELL_BYTES; g++) begin : g_flat
    assign cell_out[(CELL_BYTES-1-g)*8 +: 8] = buf_q[g];
  end

  assign en           = en_q;
  assign cell_valid   = valid_q;
  assign hec_err      = hec_err_q;
  assign cell_cnt     = cell_cnt_q;
  assign hec_err_cnt  = hec_cnt_q;
  assign sync_err_cnt = sync_cnt_q;

endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// Bench for utopia_rx_cell_assembler: a PHY byte queue feeds the DUT and a byte-list model of the
// cell rules predicts every output each cycle; a second instance with 2-bit counters covers saturation.
module tb_utopia_rx_cell_assembler;
  localparam int         CB    = 53;
  localparam int         HI    = 4;
  localparam logic [7:0] COSET = 8'h55;
  localparam int         CW    = 16;
  localparam int         SW    = 2;
  localparam int         W     = CB*8;

  logic          clk_in = 1'b0;
  logic          reset, soc, clav, cell_ready;
  logic [7:0]    data;
  logic          en, cell_valid, hec_err;
  logic [W-1:0]  cell_out;
  logic [CW-1:0] cell_cnt, hec_err_cnt, sync_err_cnt;
  logic          en_s, valid_s, hec_err_s;
  logic [W-1:0]  cell_out_s;
  logic [SW-1:0] cell_cnt_s, hec_err_cnt_s, sync_err_cnt_s;

  utopia_rx_cell_assembler #(.CELL_BYTES(CB), .HEC_IDX(HI), .HEC_COSET(COSET), .CNT_W(CW)) dut (
    .clk_in(clk_in), .reset(reset), .data(data), .soc(soc), .clav(clav), .en(en),
    .cell_out(cell_out), .cell_valid(cell_valid), .cell_ready(cell_ready), .hec_err(hec_err),
    .cell_cnt(cell_cnt), .hec_err_cnt(hec_err_cnt), .sync_err_cnt(sync_err_cnt));

  utopia_rx_cell_assembler #(.CELL_BYTES(CB), .HEC_IDX(HI), .HEC_COSET(COSET), .CNT_W(SW)) dut_s (
    .clk_in(clk_in), .reset(reset), .data(data), .soc(soc), .clav(clav), .en(en_s),
    .cell_out(cell_out_s), .cell_valid(valid_s), .cell_ready(cell_ready), .hec_err(hec_err_s),
    .cell_cnt(cell_cnt_s), .hec_err_cnt(hec_err_cnt_s), .sync_err_cnt(sync_err_cnt_s));

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;

  logic [8:0] phy_q[$];
  int gap_left = 0, gap_trigger = -1, gap_len = 0, popped = 0;
  int ready_wait = 0, ready_delay = 0, pulses = 0;

  logic [7:0]   cur[$];
  bit           collecting = 0, bad = 0, m_hold = 0, m_hec_pulse = 0;
  int           m_cell = 0, m_hec = 0, m_sync = 0;
  logic [W-1:0] m_exp = '0, last_cell = '0;

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  hec;
    int garbage, inject_at, gap_at, gap_len, rdy_dly;
    int d_cell, d_hec, d_sync;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cell(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sat(longint x, int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (x > lim) ? lim : x;
  endfunction

  // HEC as the remainder of header*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] hec_of(logic [31:0] h);
    logic [39:0] r;
    r = {h, 8'h00};
    for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [W-1:0] pack_cell(logic [31:0] hdr, logic [7:0] hec, logic [7:0] base);
    logic [W-1:0] v;
    v = '0;
    v[W-1 -: 40] = {hdr, hec};
    for (int i = 5; i < CB; i++) v[(CB-1-i)*8 +: 8] = 8'(base + 8'(i - 4));
    return v;
  endfunction

  task automatic push_cell(logic [31:0] hdr, logic [7:0] hec, logic [7:0] base, int len);
    logic [W-1:0] v;
    v = pack_cell(hdr, hec, base);
    for (int i = 0; i < len; i++) phy_q.push_back({(i == 0), v[(CB-1-i)*8 +: 8]});
  endtask

  task automatic model_byte(logic [8:0] b);
    if (b[8]) begin
      if (collecting) m_sync++;
      cur.delete();
      cur.push_back(b[7:0]);
      collecting = 1;
      bad = 0;
    end else if (!collecting) begin
      m_sync++;
    end else begin
      cur.push_back(b[7:0]);
      if (cur.size() == HI + 1 && !bad && b[7:0] != (hec_of({cur[0], cur[1], cur[2], cur[3]}) ^ COSET)) begin
        bad = 1;
        m_hec++;
        m_hec_pulse = 1;
      end
      if (cur.size() == CB) begin
        collecting = 0;
        if (!bad) begin
          for (int i = 0; i < CB; i++) m_exp[(CB-1-i)*8 +: 8] = cur[i];
          m_hold = 1;
          ready_wait = ready_delay;
        end
      end
    end
  endtask

  // Called at posedge+1: drive the next edge's inputs, advance the model across it, check at +1.
  task automatic cycle();
    bit xfer, rdy, clav_was;
    xfer = (en === 1'b0);
    clav = (gap_left == 0) && ((phy_q.size() - (xfer ? 1 : 0)) >= 1);
    if (phy_q.size() > 0) {soc, data} = phy_q[0];
    else begin soc = 1'b0; data = 8'hEE; end
    rdy = (ready_wait == 0);
    cell_ready = rdy;
    if (m_hold) chk_cell("hold_cell_out", cell_out, m_exp);
    if (m_hold && rdy) last_cell = cell_out;
    clav_was = clav;
    @(posedge clk_in);
    m_hec_pulse = 0;
    if (m_hold && rdy) begin m_hold = 0; m_cell++; end
    else if (m_hold && ready_wait > 0) ready_wait--;
    if (xfer) begin
      if (phy_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL phy_underrun: en low with no byte queued, required en high");
      end else begin
        model_byte(phy_q.pop_front());
        popped++;
      end
    end
    if (gap_left > 0) gap_left--;
    else if (xfer && popped == gap_trigger) begin gap_left = gap_len; gap_trigger = -1; end
    #1;
    if (hec_err) pulses++;
    chk("cell_valid", 64'(cell_valid), 64'(m_hold));
    chk("hec_err", 64'(hec_err), 64'(m_hec_pulse));
    chk("en", 64'(en), 64'(!(clav_was && !m_hold)));
    chk("cell_cnt", 64'(cell_cnt), 64'(sat(m_cell, CW)));
    chk("hec_err_cnt", 64'(hec_err_cnt), 64'(sat(m_hec, CW)));
    chk("sync_err_cnt", 64'(sync_err_cnt), 64'(sat(m_sync, CW)));
    chk("sat_en", 64'(en_s), 64'(!(clav_was && !m_hold)));
    chk("sat_cell_cnt", 64'(cell_cnt_s), 64'(sat(m_cell, SW)));
    chk("sat_hec_err_cnt", 64'(hec_err_cnt_s), 64'(sat(m_hec, SW)));
    chk("sat_sync_err_cnt", 64'(sync_err_cnt_s), 64'(sat(m_sync, SW)));
  endtask

  task automatic run_idle(int budget);
    int n;
    n = 0;
    while (!(phy_q.size() == 0 && !m_hold && en === 1'b1) && n < budget) begin
      cycle();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_en", 64'(en), 64'd1);
    chk("rst_valid", 64'(cell_valid), 64'd0);
    chk("rst_hec_err", 64'(hec_err), 64'd0);
    chk("rst_cell_cnt", 64'(cell_cnt), 64'd0);
    chk("rst_hec_err_cnt", 64'(hec_err_cnt), 64'd0);
    chk("rst_sync_err_cnt", 64'(sync_err_cnt), 64'd0);
    chk_cell("rst_cell_out", cell_out, '0);
    chk("rst_sat_cell_cnt", 64'(cell_cnt_s), 64'd0);
    phy_q.delete(); cur.delete();
    collecting = 0; bad = 0; m_hold = 0; m_hec_pulse = 0;
    m_cell = 0; m_hec = 0; m_sync = 0;
    gap_left = 0; gap_trigger = -1; ready_wait = 0; popped = 0;
    clav = 1'b0; cell_ready = 1'b0;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] c0, h0, s0;
    logic [31:0]   hdr;
    logic [7:0]    hec, base;
    int            base_pop;

    tbl[0] = '{32'h0000_0000, 8'h55, 0, 0, -1, 0, 0, 1, 0, 0};
    tbl[1] = '{32'h0000_0001, 8'h55, 0, 0, -1, 0, 0, 0, 1, 0};
    tbl[2] = '{32'h0000_0001, 8'h52, 0, 0, -1, 0, 0, 1, 0, 0};
    tbl[3] = '{32'h0000_0000, 8'h55, 3, 0, -1, 0, 0, 1, 0, 3};
    tbl[4] = '{32'h0000_0000, 8'h55, 0, 20, -1, 0, 0, 1, 0, 1};
    tbl[5] = '{32'h0000_0000, 8'h55, 0, 0, 10, 5, 8, 1, 0, 0};

    reset = 1'b1; clav = 1'b0; soc = 1'b0; data = 8'h00; cell_ready = 1'b0;
    #1;
    do_reset();

    for (int t = 0; t < 6; t++) begin
      c0 = cell_cnt; h0 = hec_err_cnt; s0 = sync_err_cnt; pulses = 0;
      last_cell = '0;
      ready_delay = tbl[t].rdy_dly;
      for (int g = 0; g < tbl[t].garbage; g++) phy_q.push_back({1'b0, 8'(8'hA0 + g)});
      if (tbl[t].inject_at > 0) push_cell(tbl[t].hdr, tbl[t].hec, 8'h00, tbl[t].inject_at);
      base_pop = popped + phy_q.size();
      if (tbl[t].gap_at >= 0) begin gap_trigger = base_pop + tbl[t].gap_at; gap_len = tbl[t].gap_len; end
      push_cell(tbl[t].hdr, tbl[t].hec, 8'h00, CB);
      run_idle(400);
      chk("tbl_cell_delta", 64'(cell_cnt - c0), 64'(tbl[t].d_cell));
      chk("tbl_hec_delta", 64'(hec_err_cnt - h0), 64'(tbl[t].d_hec));
      chk("tbl_sync_delta", 64'(sync_err_cnt - s0), 64'(tbl[t].d_sync));
      chk("tbl_hec_pulses", 64'(pulses), 64'(tbl[t].d_hec));
      if (tbl[t].d_cell == 1) chk_cell("tbl_cell", last_cell, pack_cell(tbl[t].hdr, tbl[t].hec, 8'h00));
      if (t == 0) begin
        chk("tbl_hdr_hec", last_cell[423:384], 64'h00_0000_0055);
        chk("tbl_last_byte", 64'(last_cell[7:0]), 64'h30);
      end
    end

    for (int r = 0; r < 30; r++) begin
      hdr = $urandom;
      base = 8'($urandom);
      hec = hec_of(hdr) ^ COSET;
      if ($urandom_range(0, 3) == 0) hec = hec ^ 8'(1 << $urandom_range(0, 7));
      ready_delay = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) phy_q.push_back({1'b0, 8'($urandom)});
      if ($urandom_range(0, 5) == 0) push_cell(hdr, hec, base, $urandom_range(1, CB - 1));
      if ($urandom_range(0, 2) == 0) begin
        gap_trigger = popped + phy_q.size() + $urandom_range(1, 50);
        gap_len = $urandom_range(1, 6);
      end
      push_cell(hdr, hec, base, CB);
      run_idle(400);
      gap_trigger = -1;
    end

    ready_delay = 0;
    push_cell(32'h0, 8'h55, 8'h00, CB);
    base_pop = popped;
    for (int n = 0; n < 200 && popped < base_pop + 30; n++) cycle();
    do_reset();
    push_cell(32'h0, 8'h55, 8'h00, CB);
    run_idle(400);
    chk("rst_mid_cell_cnt", 64'(cell_cnt), 64'd1);
    chk_cell("rst_mid_cell", last_cell, pack_cell(32'h0, 8'h55, 8'h00));

    do_reset();
    for (int k = 0; k < 5; k++) push_cell(32'h0000_0001, 8'h52, 8'(k * 16), CB);
    run_idle(800);
    chk("sat5_cell_cnt", 64'(cell_cnt), 64'd5);
    chk("sat5_sat_cell_cnt", 64'(cell_cnt_s), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
